// File: rtl/exp4_captura_pkg.sv
// Shared types and constants for the play-capture block.
// Holds the FSM state enum, the db_estado display codes and the default debounce length.
// Optional feature macro used by the top: CAPTURA_UNICA_TECLA_EN (single-key-only capture).
package exp4_captura_pkg;

    typedef enum logic [2:0] {
        ST_INICIAL  = 3'd0,
        ST_ESPERA   = 3'd1,
        ST_FILTRO   = 3'd2,
        ST_REGISTRA = 3'd3,
        ST_SOLTA    = 3'd4
    } estado_t;

    localparam logic [3:0] DB_INICIAL  = 4'd0;
    localparam logic [3:0] DB_ESPERA   = 4'd1;
    localparam logic [3:0] DB_FILTRO   = 4'd2;
    localparam logic [3:0] DB_REGISTRA = 4'd3;
    localparam logic [3:0] DB_SOLTA    = 4'd4;

    localparam int DEBOUNCE_CICLOS_PADRAO = 50000;

    // True when more than one key is pressed at once (clearing the lowest set bit leaves something).
    function automatic logic mais_de_um_bit(input logic [3:0] v);
        return (v & (v - 4'd1)) != 4'd0;
    endfunction

endpackage

// File: rtl/exp4_sincronizador.sv
// Two-flop synchronizer bringing asynchronous key inputs into the clock domain.
// Ports: clock, reset (async, active-high), d (raw input), q (synchronized output).
// Latency: two clock edges; no backpressure.
module exp4_sincronizador #(
    parameter int LARGURA = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [LARGURA-1:0] d,
    output logic [LARGURA-1:0] q
);

    logic [LARGURA-1:0] meta_q, meta_d;
    logic [LARGURA-1:0] sinc_q, sinc_d;

    always_comb begin
        meta_d = d;
        sinc_d = meta_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_q <= '0;
            sinc_q <= '0;
        end else begin
            meta_q <= meta_d;
            sinc_q <= sinc_d;
        end
    end

    assign q = sinc_q;

endmodule

// File: rtl/exp4_captura_jogada.sv
// Debounced capture of a player key pattern; emits a one-cycle jogada_feita with the registered pattern.
// Ports: clock, reset (async, active-high), chaves[3:0], habilita -> jogada[3:0], jogada_feita, db_estado[3:0].
// Latency: pulse in the cycle after edge k+2+DEBOUNCE_CICLOS; macro CAPTURA_UNICA_TECLA_EN rejects multi-key plays.
module exp4_captura_jogada
    import exp4_captura_pkg::*;
#(
    parameter int DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] chaves,
    input  logic       habilita,
    output logic [3:0] jogada,
    output logic       jogada_feita,
    output logic [3:0] db_estado
);

    // Counter only needs to reach DEBOUNCE_CICLOS-1; keep at least one bit for the degenerate case.
    localparam int CNT_W = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CICLOS - 1);

    logic [3:0]       sinc;
    estado_t          estado_q, estado_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       candidato_q, candidato_d;
    logic [3:0]       jogada_q, jogada_d;

    exp4_sincronizador #(
        .LARGURA (4)
    ) u_sinc (
        .clock (clock),
        .reset (reset),
        .d     (chaves),
        .q     (sinc)
    );

    // State and datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q    <= ST_INICIAL;
            cnt_q       <= '0;
            candidato_q <= '0;
            jogada_q    <= '0;
        end else begin
            estado_q    <= estado_d;
            cnt_q       <= cnt_d;
            candidato_q <= candidato_d;
            jogada_q    <= jogada_d;
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        estado_d    = estado_q;
        cnt_d       = cnt_q;
        candidato_d = candidato_q;
        jogada_d    = jogada_q;
        case (estado_q)
            ST_INICIAL: begin
                if (habilita) estado_d = ST_ESPERA;
            end
            ST_ESPERA: begin
                if (!habilita) begin
                    estado_d = ST_INICIAL;
                end else if (sinc != 4'd0) begin
                    estado_d    = ST_FILTRO;
                    candidato_d = sinc;
                    cnt_d       = '0;
                end
            end
            ST_FILTRO: begin
                if (!habilita) begin
                    estado_d = ST_INICIAL;
                end else if (sinc != candidato_q) begin
                    // Bounce or extra key: requalify from scratch.
                    estado_d = ST_ESPERA;
                end else if (cnt_q == CNT_MAX) begin
`ifdef CAPTURA_UNICA_TECLA_EN
                    if (mais_de_um_bit(candidato_q)) begin
                        // Chord rejected: wait for release without touching jogada.
                        estado_d = ST_SOLTA;
                        cnt_d    = '0;
                    end else begin
                        estado_d = ST_REGISTRA;
                        jogada_d = candidato_q;
                    end
`else
                    estado_d = ST_REGISTRA;
                    jogada_d = candidato_q;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_REGISTRA: begin
                estado_d = ST_SOLTA;
                cnt_d    = '0;
            end
            ST_SOLTA: begin
                // Any key still down restarts the release window, so a held key fires only once.
                if (sinc != 4'd0) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_MAX) begin
                    estado_d = habilita ? ST_ESPERA : ST_INICIAL;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                estado_d = ST_INICIAL;
            end
        endcase
    end

    // Moore outputs.
    always_comb begin
        jogada_feita = 1'b0;
        db_estado    = DB_INICIAL;
        case (estado_q)
            ST_INICIAL:  db_estado = DB_INICIAL;
            ST_ESPERA:   db_estado = DB_ESPERA;
            ST_FILTRO:   db_estado = DB_FILTRO;
            ST_REGISTRA: begin
                db_estado    = DB_REGISTRA;
                jogada_feita = 1'b1;
            end
            ST_SOLTA:    db_estado = DB_SOLTA;
            default:     db_estado = DB_INICIAL;
        endcase
    end

    assign jogada = jogada_q;

endmodule
